// File: rtl/ram_burst_ctrl_pkg.sv
// rtl/ram_burst_ctrl_pkg.sv - shared opcode/state types and default sizes for the burst RAM controller
package RAM_shared_pkg;

    localparam int ADDR_SIZE_DEF = 8;
    localparam int DATA_SIZE_DEF = 8;
    localparam int MEM_DEPTH_DEF = 256;

    typedef enum logic [1:0] {
        SET_WADDR = 2'b00,
        WR_DATA   = 2'b01,
        SET_RADDR = 2'b10,
        RD_DATA   = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        W_ARM  = 2'b01,
        R_ARM  = 2'b10,
        WR_ARM = 2'b11
    } state_e;

    // Encodes the pair of armed flags back into a state.
    function automatic state_e arm_state(input logic i_w_armed, input logic i_r_armed);
        case ({i_r_armed, i_w_armed})
            2'b01:   arm_state = W_ARM;
            2'b10:   arm_state = R_ARM;
            2'b11:   arm_state = WR_ARM;
            default: arm_state = IDLE;
        endcase
    endfunction

endpackage

// File: rtl/ram_burst_ctrl_mem.sv
// rtl/ram_burst_ctrl_mem.sv - single-port synchronous word array with write enable and registered read
module ram_burst_mem
    import RAM_shared_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_we,
    input  logic                 i_re,
    input  logic [ADDR_SIZE-1:0] i_addr,
    input  logic [DATA_SIZE-1:0] i_wdata,
    output logic [DATA_SIZE-1:0] o_rdata
);

    logic [DATA_SIZE-1:0] r_mem [MEM_DEPTH];
    logic [DATA_SIZE-1:0] r_rdata;

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_burst_ctrl.sv
// rtl/ram_burst_ctrl.sv - opcode-driven burst RAM controller: decode, arming FSM, address counters, sticky error
module ram_burst_ctrl
    import RAM_shared_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int AUTO_INC  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_SIZE+1:0] din,
    input  logic                 rx_valid,
    input  logic                 err_clr,
    output logic [DATA_SIZE-1:0] dout,
    output logic                 tx_valid,
    output logic                 err
);

    localparam logic [ADDR_SIZE:0] DEPTH_L = (ADDR_SIZE+1)'(MEM_DEPTH);

    state_e               r_state;
    state_e               w_next_state;
    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [ADDR_SIZE-1:0] r_rd_addr;
    logic                 r_tx_valid;
    logic                 r_err;

    opcode_e              w_op;
    logic [DATA_SIZE-1:0] w_payload;
    logic                 w_w_armed;
    logic                 w_r_armed;
    logic                 w_wr_in_range;
    logic                 w_rd_in_range;
    logic                 w_set_waddr;
    logic                 w_set_raddr;
    logic                 w_wr_inc;
    logic                 w_rd_inc;
    logic                 w_mem_we;
    logic                 w_mem_re;
    logic                 w_err_set;
    logic [ADDR_SIZE-1:0] w_mem_addr;

    assign w_op          = opcode_e'(din[DATA_SIZE+1:DATA_SIZE]);
    assign w_payload     = din[DATA_SIZE-1:0];
    assign w_w_armed     = (r_state == W_ARM) || (r_state == WR_ARM);
    assign w_r_armed     = (r_state == R_ARM) || (r_state == WR_ARM);
    assign w_wr_in_range = {1'b0, r_wr_addr} < DEPTH_L;
    assign w_rd_in_range = {1'b0, r_rd_addr} < DEPTH_L;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (rx_valid) begin
            case (w_op)
                SET_WADDR: w_next_state = arm_state(1'b1, w_r_armed);
                SET_RADDR: w_next_state = arm_state(w_w_armed, 1'b1);
                default:   w_next_state = r_state;
            endcase
        end
    end

    // Accepted accesses still advance the address when out of range so a burst wraps.
    always_comb begin
        w_set_waddr = 1'b0;
        w_set_raddr = 1'b0;
        w_wr_inc    = 1'b0;
        w_rd_inc    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;
        w_err_set   = 1'b0;
        if (rx_valid) begin
            case (w_op)
                SET_WADDR: w_set_waddr = 1'b1;
                SET_RADDR: w_set_raddr = 1'b1;
                WR_DATA: begin
                    if (!w_w_armed) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_wr_inc  = 1'b1;
                        w_mem_we  = w_wr_in_range;
                        w_err_set = !w_wr_in_range;
                    end
                end
                RD_DATA: begin
                    if (!w_r_armed) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_rd_inc  = 1'b1;
                        w_mem_re  = w_rd_in_range;
                        w_err_set = !w_rd_in_range;
                    end
                end
                default: w_err_set = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr <= '0;
            r_rd_addr <= '0;
        end else begin
            if (w_set_waddr) begin
                r_wr_addr <= w_payload[ADDR_SIZE-1:0];
            end else if (w_wr_inc && (AUTO_INC != 0)) begin
                r_wr_addr <= r_wr_addr + 1'b1;
            end
            if (w_set_raddr) begin
                r_rd_addr <= w_payload[ADDR_SIZE-1:0];
            end else if (w_rd_inc && (AUTO_INC != 0)) begin
                r_rd_addr <= r_rd_addr + 1'b1;
            end
        end
    end

    // A new error outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_tx_valid <= w_mem_re;
            r_err      <= w_err_set | (r_err & ~err_clr);
        end
    end

    assign w_mem_addr = w_mem_we ? r_wr_addr : r_rd_addr;

    ram_burst_mem #(
        .ADDR_SIZE (ADDR_SIZE),
        .DATA_SIZE (DATA_SIZE),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (w_mem_addr),
        .i_wdata (w_payload),
        .o_rdata (dout)
    );

    assign tx_valid = r_tx_valid;
    assign err      = r_err;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb/tb_ram_burst_ctrl.sv - directed bench for ram_burst_ctrl across default, depth-200 and no-increment builds
module tb_ram_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] din;
    logic       rx_valid;
    logic       err_clr;

    logic [7:0] dout_a, dout_b, dout_c;
    logic       tx_a, tx_b, tx_c;
    logic       err_a, err_b, err_c;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ram_burst_ctrl u_def (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .err_clr(err_clr),
        .dout(dout_a), .tx_valid(tx_a), .err(err_a)
    );

    ram_burst_ctrl #(.MEM_DEPTH(200)) u_d200 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .err_clr(err_clr),
        .dout(dout_b), .tx_valid(tx_b), .err(err_b)
    );

    ram_burst_ctrl #(.AUTO_INC(0)) u_ninc (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .err_clr(err_clr),
        .dout(dout_c), .tx_valid(tx_c), .err(err_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic chk_ne(input string tag, input logic [31:0] obs, input logic [31:0] bad);
        n_total++;
        assert (obs !== bad) n_pass++;
        else $error("FAIL %s observed=0x%0h expected anything but 0x%0h", tag, obs, bad);
    endtask

    // One command per cycle; outputs are sampled at the following falling edge.
    task automatic send(input logic [1:0] op, input logic [7:0] pl);
        din      = {op, pl};
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        din      = '0;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        din      = '0;
        rx_valid = 1'b0;
        err_clr  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_dout", dout_a, 0);
        chk("reset_tx", tx_a, 0);
        chk("reset_err", err_a, 0);
        rst_n = 1'b1;
        @(negedge clk);

        send(2'b01, 8'h55);
        chk("unarmed_wr_err", err_a, 1);
        send(2'b11, 8'h00);
        chk("unarmed_rd_tx", tx_a, 0);
        chk("unarmed_rd_err", err_a, 1);
        send(2'b10, 8'h00);
        send(2'b11, 8'h00);
        chk("rd0_tx", tx_a, 1);
        chk_ne("rd0_not_55", dout_a, 8'h55);
        clear_err();
        chk("err_cleared", err_a, 0);

        send(2'b00, 8'h10);
        send(2'b01, 8'hA1);
        send(2'b01, 8'hA2);
        send(2'b01, 8'hA3);
        send(2'b10, 8'h10);
        send(2'b11, 8'h00);
        chk("burst1_tx", tx_a, 1);
        chk("burst1_dout", dout_a, 8'hA1);
        send(2'b11, 8'h00);
        chk("burst2_tx", tx_a, 1);
        chk("burst2_dout", dout_a, 8'hA2);
        send(2'b11, 8'h00);
        chk("burst3_tx", tx_a, 1);
        chk("burst3_dout", dout_a, 8'hA3);
        @(negedge clk);
        chk("burst_end_tx", tx_a, 0);
        chk("burst_err", err_a, 0);

        send(2'b00, 8'h20);
        send(2'b10, 8'h20);
        send(2'b01, 8'h77);
        send(2'b11, 8'h00);
        chk("wr_then_rd_tx", tx_a, 1);
        chk("wr_then_rd_dout", dout_a, 8'h77);

        send(2'b00, 8'hC7);
        send(2'b01, 8'hB0);
        chk("d200_199_err", err_b, 0);
        send(2'b01, 8'hB1);
        chk("d200_200_err", err_b, 1);
        chk("def_200_err", err_a, 0);
        send(2'b01, 8'hB2);
        send(2'b01, 8'hB3);
        chk("d200_202_err", err_b, 1);
        send(2'b10, 8'hC8);
        send(2'b11, 8'h00);
        chk("def_rd200_dout", dout_a, 8'hB1);
        chk("d200_rd200_tx", tx_b, 0);
        send(2'b10, 8'hC7);
        send(2'b11, 8'h00);
        chk("d200_rd199_tx", tx_b, 1);
        chk("d200_rd199_dout", dout_b, 8'hB0);
        clear_err();

        send(2'b00, 8'hFF);
        send(2'b01, 8'h11);
        send(2'b01, 8'h22);
        send(2'b10, 8'h00);
        send(2'b11, 8'h00);
        chk("wrap_dout", dout_a, 8'h22);
        chk("wrap_err", err_a, 0);

        send(2'b00, 8'h05);
        send(2'b01, 8'h5A);
        send(2'b10, 8'h05);
        send(2'b11, 8'h00);
        chk("ninc1_tx", tx_c, 1);
        chk("ninc1_dout", dout_c, 8'h5A);
        send(2'b11, 8'h00);
        chk("ninc2_tx", tx_c, 1);
        chk("ninc2_dout", dout_c, 8'h5A);

        send(2'b00, 8'h30);
        send(2'b01, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_dout", dout_a, 0);
        chk("midrst_ninc_dout", dout_c, 0);
        chk("midrst_tx", tx_a, 0);
        chk("midrst_err", err_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(2'b01, 8'h02);
        chk("postrst_wr_err", err_a, 1);

        clear_err();
        chk("pre_collide_err", err_a, 0);
        err_clr = 1'b1;
        send(2'b11, 8'h00);
        err_clr = 1'b0;
        chk("collide_err", err_a, 1);
        chk("collide_tx", tx_a, 0);
        clear_err();
        chk("collide_cleared", err_a, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ram_burst_ctrl.md
RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 8, meaning address width in bits.
REQ-002 SHALL have parameter DATA_SIZE, default 8, meaning word width in bits; legal only when DATA_SIZE >= ADDR_SIZE.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, meaning number of words; legal only when MEM_DEPTH <= 2**ADDR_SIZE.
REQ-004 SHALL have parameter AUTO_INC, default 1, meaning post-increment of the active address after each data or read command (0 = disabled).
REQ-005 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-007 SHALL have port din, input, DATA_SIZE+2; din[DATA_SIZE+1:DATA_SIZE] is the opcode, din[DATA_SIZE-1:0] is the payload.
REQ-008 SHALL have port rx_valid, input, 1, qualifies din for one cycle.
REQ-009 SHALL have port err_clr, input, 1, synchronous clear of err.
REQ-010 SHALL have port dout, output, DATA_SIZE, registered read data.
REQ-011 SHALL have port tx_valid, output, 1, one-cycle pulse marking dout valid.
REQ-012 SHALL have port err, output, 1, sticky protocol or range error.

Function
REQ-013 SHALL decode opcodes when rx_valid=1 and ignore din entirely when rx_valid=0.
- 00: wr_addr <= payload[ADDR_SIZE-1:0]
- 01: mem[wr_addr] <= payload
- 10: rd_addr <= payload[ADDR_SIZE-1:0]
- 11: dout <= mem[rd_addr]
REQ-014 SHALL implement a state machine with states IDLE, W_ARM, R_ARM and WR_ARM, where W_ARM means a write address is held, R_ARM means a read address is held, and WR_ARM means both are held.
- Opcode 00 adds write-armed.
- Opcode 10 adds read-armed.
- No other opcode changes the state.
REQ-015 SHALL flag opcode 01 issued while not write-armed as an error: set err and perform no memory write.
REQ-016 SHALL flag opcode 11 issued while not read-armed as an error: set err, leave dout unchanged and issue no tx_valid pulse.
REQ-017 SHALL assert tx_valid for exactly one cycle, on the cycle after an accepted opcode 11, with dout updated on that same edge.
REQ-018 SHALL drive tx_valid=0 in every other cycle; back-to-back reads SHALL produce back-to-back pulses.
REQ-019 SHALL, when AUTO_INC=1, increment wr_addr after an accepted opcode 01 and rd_addr after an accepted opcode 11, modulo 2**ADDR_SIZE.
REQ-020 SHALL, when AUTO_INC=0, keep both addresses unchanged except by opcodes 00 and 10.
REQ-021 SHALL treat an address >= MEM_DEPTH on access (opcode 01 or 11) as a range error.
- Set err.
- Suppress the write, or suppress the read and its tx_valid.
- Still apply the auto-increment, so a burst wraps through 2**ADDR_SIZE back to valid addresses.
REQ-022 SHALL make err sticky: it remains set until err_clr=1, and an error in the same cycle as err_clr SHALL win (err stays 1).
REQ-023 SHALL return the new data for a read of an address written in the immediately preceding cycle.

Reset
REQ-024 SHALL, while rst_n=0, immediately force the outputs and registers to their reset values: tx_valid=0, dout=0, err=0, wr_addr=0, rd_addr=0, state=IDLE.
REQ-025 SHALL NOT reset memory contents.
REQ-026 SHALL, on reset asserted mid-burst, abort the burst: after release the block is unarmed and opcodes 01 and 11 error until re-addressed.

Structure
REQ-027 SHALL place the opcode enum (SET_WADDR, WR_DATA, SET_RADDR, RD_DATA), the state enum and the default ADDR_SIZE/DATA_SIZE/MEM_DEPTH constants in RAM_shared_pkg.
REQ-028 SHALL split the design into one sub-module, ram_burst_mem: a single-port synchronous array with write enable and registered read.
REQ-029 SHALL keep all decode, FSM, address counter and error logic in ram_burst_ctrl.

Verification
REQ-030 SHALL cover burst write then read, with defaults and AUTO_INC=1:
- Stimulus: 00/0x10, 01/0xA1, 01/0xA2, 01/0xA3, then 10/0x10, then three 11 commands back-to-back.
- Required response: three consecutive tx_valid pulses with dout = A1, A2, A3.
REQ-031 SHALL cover commands without a prior address after reset:
- Stimulus: 01/0x55 then 11.
- Required response: err=1, no tx_valid pulse, and a later read of address 0 does not return 0x55.
REQ-032 SHALL cover range error and wrap, with MEM_DEPTH=200:
- Stimulus: 00/0xC7, then four 01 commands.
- Required response: address 199 written, err=1 for addresses 200-202, and writes suppressed for those addresses.
REQ-033 SHALL cover AUTO_INC=0:
- Stimulus: 10/0x05, then two 11 commands.
- Required response: both pulses return mem[5].
REQ-034 SHALL cover reset mid-burst:
- Stimulus: rst_n=0 asserted between two 01 commands.
- Required response: outputs are 0 immediately, and a subsequent 01 sets err.
REQ-035 SHALL cover err clear collision:
- Stimulus: err_clr=1 in the same cycle as a fresh unarmed 11.
- Required response: err remains 1, and clears only on the next err_clr with no error.
